iomem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the PicoSoC iomem bus.
- Master 0 is the CPU iomem port; master 1 is a secondary bus master, e.g. a future DSP coefficient loader or DMA.
- The slave side drives the existing OR-combined peripheral bus: gpio, audio_engine and any later peripherals.
- Grants round-robin, holds each grant for one full transaction, and optionally aborts hung transactions with a watchdog.

---
 rtl/iomem_pkg.sv | 29 ++
 rtl/iomem_watchdog.sv | 44 ++++
 rtl/iomem_arbiter.sv | 159 +++++++++++++++
 tb/tb_iomem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem two-master arbiter: bus widths, FSM state
// encoding, default timeout read data and the round-robin pick helper.
package iomem_pkg;

  localparam int IOMEM_AW = 32;
  localparam int IOMEM_DW = 32;
  localparam int IOMEM_SW = 4;

  localparam logic [31:0] IOMEM_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } iomem_state_e;

  // Round-robin choice: a lone requester wins; on contention the master that
  // was not granted last time wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    logic pick;
    if (v0 && v1) begin
      pick = ~last;
    end else begin
      pick = v1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/iomem_watchdog.sv
// Busy-cycle watchdog for the iomem arbiter. Counts BUSY cycles from zero and
// flags expiry in the BUSY cycle whose count equals TIMEOUT-1, i.e. the
// TIMEOUT-th BUSY cycle. Instantiated only when IOMEM_ARB_TIMEOUT_EN is set.
module iomem_watchdog
  import iomem_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic ck,
  input  logic rst,
  input  logic start_i,
  input  logic busy_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear when a transaction is launched, advance while busy.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = 16'd0;
    end else if (busy_i) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with asynchronous active-low reset.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = busy_i && (cnt_q == LIMIT);

endmodule

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC iomem bus. One transaction
// at a time: IDLE (arbitrate, latch request) -> BUSY (drive peripheral bus
// until s_ready) -> DONE (one-cycle ready pulse to the granted master).
// Optional watchdog abort on hung peripherals: define IOMEM_ARB_TIMEOUT_EN.
module iomem_arbiter
  import iomem_pkg::*;
#(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = IOMEM_ERR_DATA
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [IOMEM_SW-1:0] m0_wstrb,
  input  logic [IOMEM_AW-1:0] m0_addr,
  input  logic [IOMEM_DW-1:0] m0_wdata,
  output logic [IOMEM_DW-1:0] m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [IOMEM_SW-1:0] m1_wstrb,
  input  logic [IOMEM_AW-1:0] m1_addr,
  input  logic [IOMEM_DW-1:0] m1_wdata,
  output logic [IOMEM_DW-1:0] m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [IOMEM_SW-1:0] s_wstrb,
  output logic [IOMEM_AW-1:0] s_addr,
  output logic [IOMEM_DW-1:0] s_wdata,
  input  logic [IOMEM_DW-1:0] s_rdata,
  output logic                timeout,
  output logic                grant
);

  iomem_state_e        state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [IOMEM_AW-1:0] addr_q, addr_d;
  logic [IOMEM_DW-1:0] wdata_q, wdata_d;
  logic [IOMEM_SW-1:0] wstrb_q, wstrb_d;
  logic [IOMEM_DW-1:0] rdata_q, rdata_d;
  logic                to_q, to_d;
  logic                sel_s;
  logic                start_s;
  logic                expired_s;
  logic                done_s;

  assign start_s = (state_q == ST_IDLE) && (m0_valid || m1_valid);

`ifdef IOMEM_ARB_TIMEOUT_EN
  iomem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .ck        (ck),
    .rst       (rst),
    .start_i   (start_s),
    .busy_i    (state_q == ST_BUSY),
    .expired_o (expired_s)
  );
`else
  // Without the watchdog a BUSY transaction waits for s_ready indefinitely.
  assign expired_s = 1'b0;
`endif

  // Next-state and datapath: arbitrate in IDLE, wait for completion in BUSY,
  // retire the grant in DONE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    sel_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          sel_s   = rr_pick(m0_valid, m1_valid, last_q);
          grant_d = sel_s;
          if (sel_s) begin
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            wstrb_d = m1_wstrb;
          end else begin
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            wstrb_d = m0_wstrb;
          end
          to_d    = 1'b0;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A peripheral answer in the expiry cycle takes priority over abort.
        if (s_ready) begin
          rdata_d = s_rdata;
          to_d    = 1'b0;
          state_d = ST_DONE;
        end else if (expired_s) begin
          rdata_d = ERR_DATA;
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; last-grant starts at 1 so master 0 wins
  // the first contention.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
    end
  end

  // Outputs are decoded from registers only; the ungranted master always
  // sees zero so the master-side buses stay OR-safe.
  assign done_s   = (state_q == ST_DONE);
  assign s_valid  = (state_q == ST_BUSY);
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign m0_ready = done_s && !grant_q;
  assign m1_ready = done_s && grant_q;
  assign m0_rdata = m0_ready ? rdata_q : 32'd0;
  assign m1_rdata = m1_ready ? rdata_q : 32'd0;
  assign timeout  = done_s && to_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Randomised scoreboard bench for iomem_arbiter. Stimulus pushes expected
// peripheral-side requests and master-side responses; a slave responder and
// a master-side monitor pop and compare independently. Timeout behaviour is
// predicted only when IOMEM_ARB_TIMEOUT_EN is defined.
module tb_iomem_arbiter;
  import iomem_pkg::*;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        ck;
  logic        rst;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        timeout, grant;

  iomem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .ck(ck), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .timeout(timeout), .grant(grant)
  );

  typedef struct {
    logic        mst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    logic        mst;
    logic [31:0] rdata;
    logic        to;
  } rsp_t;

  txn_t slv_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   last_m;

  initial ck = 1'b0;
  always #5 ck = ~ck;
  always @(posedge ck) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic mst, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input int d, input logic [31:0] rd);
    txn_t t;
    t.mst = mst; t.addr = a; t.wdata = wd; t.wstrb = ws; t.delay = d; t.rdata = rd;
    return t;
  endfunction

  // A peripheral that answers after 'delay' wait cycles aborts if delay >= TO.
  function automatic bit timed_f(input int d);
`ifdef IOMEM_ARB_TIMEOUT_EN
    return d >= TO;
`else
    return 1'b0;
`endif
  endfunction

  // Number of BUSY cycles a transaction occupies.
  function automatic int dur_f(input int d);
    return timed_f(d) ? TO : d + 1;
  endfunction

  // Slave responder: checks the forwarded request every BUSY cycle and
  // raises s_ready after the transaction's wait cycles; junk on s_rdata otherwise.
  txn_t cur;
  bit   active = 1'b0;
  int   cnt = 0;
  always @(negedge ck) begin
    if (!rst) begin
      active  = 1'b0;
      s_ready = 1'b0;
      s_rdata = 32'd0;
    end else if (s_valid) begin
      if (!active) begin
        checks++;
        if (slv_q.size() == 0) begin
          errors++;
          $display("FAIL slave_unexpected actual=%h expected=none", s_addr);
          cur = mk(1'b0, s_addr, s_wdata, s_wstrb, 0, 32'd0);
        end else begin
          cur = slv_q.pop_front();
        end
        active = 1'b1;
        cnt    = cur.delay;
      end else if (cnt > 0) begin
        cnt--;
      end
      chk("s_addr", s_addr, cur.addr);
      chk("s_wdata", s_wdata, cur.wdata);
      chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, cur.wstrb});
      s_ready = (cnt == 0);
      s_rdata = (cnt == 0) ? cur.rdata : $urandom();
    end else begin
      active  = 1'b0;
      s_ready = 1'b0;
      s_rdata = $urandom();
    end
  end

  // Master-side monitor: every ready pulse must match the next predicted response.
  rsp_t r;
  always @(negedge ck) begin
    if (m0_ready || m1_ready) begin
      chk("single_ready", {31'd0, m0_ready & m1_ready}, 32'd0);
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready actual=m%0d expected=none", m1_ready);
      end else begin
        r = rsp_q.pop_front();
        chk("ready_master", {31'd0, m1_ready}, {31'd0, r.mst});
        chk("rdata", m1_ready ? m1_rdata : m0_rdata, r.rdata);
        chk("timeout", {31'd0, timeout}, {31'd0, r.to});
        chk("grant", {31'd0, grant}, {31'd0, r.mst});
      end
      chk("other_rdata_zero", m1_ready ? m0_rdata : m1_rdata, 32'd0);
    end else begin
      chk("m0_rdata_idle", m0_rdata, 32'd0);
      chk("m1_rdata_idle", m1_rdata, 32'd0);
      chk("timeout_idle", {31'd0, timeout}, 32'd0);
    end
  end

  task automatic push_txn(input txn_t t);
    rsp_t e;
    slv_q.push_back(t);
    e.mst   = t.mst;
    e.to    = timed_f(t.delay);
    e.rdata = e.to ? ERR : t.rdata;
    rsp_q.push_back(e);
  endtask

  // One round: the chosen masters request together; the model predicts the
  // service order and each master's ready latency from the arbitration rules.
  task automatic run_round(input bit do0, input bit do1, input txn_t t0, input txn_t t1,
                           input int drop0_after);
    bit first;
    int start, n, lat0, lat1, exp0, exp1, fdone;
    bit pend0, pend1;
    first = (do0 && do1) ? ~last_m : do1;
    if (do0 && do1) begin
      push_txn(first ? t1 : t0);
      push_txn(first ? t0 : t1);
      fdone = 1 + dur_f(first ? t1.delay : t0.delay);
      exp0  = first ? fdone + 2 + dur_f(t0.delay) : fdone;
      exp1  = first ? fdone : fdone + 2 + dur_f(t1.delay);
      last_m = ~first;
    end else begin
      push_txn(do1 ? t1 : t0);
      exp0 = 1 + dur_f(t0.delay);
      exp1 = 1 + dur_f(t1.delay);
      last_m = do1;
    end
    @(negedge ck);
    m0_valid = do0; m0_addr = t0.addr; m0_wdata = t0.wdata; m0_wstrb = t0.wstrb;
    m1_valid = do1; m1_addr = t1.addr; m1_wdata = t1.wdata; m1_wstrb = t1.wstrb;
    start = cyc; pend0 = do0; pend1 = do1; n = 0; lat0 = -1; lat1 = -1;
    while ((pend0 || pend1) && n < 300) begin
      @(negedge ck);
      n++;
      if (pend0 && m0_ready) begin pend0 = 1'b0; m0_valid = 1'b0; lat0 = cyc - start; end
      if (pend1 && m1_ready) begin pend1 = 1'b0; m1_valid = 1'b0; lat1 = cyc - start; end
      if (drop0_after > 0 && n == drop0_after) m0_valid = 1'b0;
    end
    if (pend0 || pend1) begin
      checks++;
      errors++;
      $display("FAIL round_bound actual=pending(%0d,%0d) expected=done", pend0, pend1);
      m0_valid = 1'b0; m1_valid = 1'b0;
      slv_q.delete(); rsp_q.delete();
    end else begin
      if (do0) chk("lat_m0", lat0, exp0);
      if (do1) chk("lat_m1", lat1, exp1);
    end
    @(negedge ck);
  endtask

  initial begin
    bit   s0, s1;
    txn_t a, b;
    rst = 1'b0; last_m = 1'b1;
    m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
    repeat (3) @(negedge ck);
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    rst = 1'b1;
    @(negedge ck);

    // Contention straight out of reset: m0 first, then alternation.
    run_round(1'b1, 1'b1, mk(1'b0, 32'h0300_0000, 32'd0, 4'h0, 1, 32'h1111_0000),
              mk(1'b1, 32'h0600_0004, 32'd0, 4'h0, 2, 32'h2222_0000), 0);
    for (int i = 0; i < 3; i++)
      run_round(1'b1, 1'b1, mk(1'b0, 32'h0300_0000, 32'd0, 4'h0, i, $urandom()),
                mk(1'b1, 32'h0600_0004, 32'd0, 4'h0, 1, $urandom()), 0);

    // m0 write with 1-cycle peripheral latency: ready 3 cycles after valid.
    run_round(1'b1, 1'b0, mk(1'b0, 32'h0300_0000, 32'h0000_00A5, 4'hF, 1, 32'd0),
              mk(1'b1, 32'd0, 32'd0, 4'h0, 0, 32'd0), 0);
    // m1 read with 5 wait cycles.
    run_round(1'b0, 1'b1, mk(1'b0, 32'd0, 32'd0, 4'h0, 0, 32'd0),
              mk(1'b1, 32'h0600_0010, 32'd0, 4'h0, 5, 32'h1234_5678), 0);
    // m0 drops valid mid-transaction.
    run_round(1'b1, 1'b0, mk(1'b0, 32'h0300_0008, 32'h5A5A_0001, 4'h3, 4, 32'h0BAD_F00D),
              mk(1'b1, 32'd0, 32'd0, 4'h0, 0, 32'd0), 2);
    // Watchdog boundary: never ready within TO cycles, then ready in cycle TO.
    run_round(1'b1, 1'b0, mk(1'b0, 32'h0300_0000, 32'd0, 4'h0, 20, 32'hCAFE_0001),
              mk(1'b1, 32'd0, 32'd0, 4'h0, 0, 32'd0), 0);
    run_round(1'b0, 1'b1, mk(1'b0, 32'd0, 32'd0, 4'h0, 0, 32'd0),
              mk(1'b1, 32'h0600_0000, 32'd0, 4'h0, TO - 1, 32'hCAFE_0002), 0);

    // Asynchronous reset in the middle of a long BUSY phase.
    slv_q.push_back(mk(1'b0, 32'h0300_0040, 32'h0, 4'h0, 50, 32'h0));
    @(negedge ck);
    m0_valid = 1'b1; m0_addr = 32'h0300_0040; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    repeat (3) @(negedge ck);
    chk("busy_before_rst", {31'd0, s_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("arst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("arst_rdata", m0_rdata | m1_rdata, 32'd0);
    chk("arst_timeout", {31'd0, timeout}, 32'd0);
    m0_valid = 1'b0;
    slv_q.delete(); rsp_q.delete();
    last_m = 1'b1;
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    run_round(1'b1, 1'b1, mk(1'b0, 32'h0300_0000, 32'd0, 4'h0, 0, 32'hAAAA_0000),
              mk(1'b1, 32'h0600_0004, 32'd0, 4'h0, 0, 32'hBBBB_0000), 0);

    // Randomised rounds.
    for (int i = 0; i < 40; i++) begin
      s0 = $urandom_range(0, 1);
      s1 = s0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a = mk(1'b0, $urandom(), $urandom(), 4'($urandom()), $urandom_range(0, 10), $urandom());
      b = mk(1'b1, $urandom(), $urandom(), 4'($urandom()), $urandom_range(0, 10), $urandom());
      run_round(s0, s1, a, b, (s0 && !s1 && ($urandom_range(0, 3) == 0)) ? 2 : 0);
    end

    chk("scoreboard_empty", rsp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
